// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 UART receive framer with valid/ack holding register
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic       Rx_in,
    input  logic       f_edge,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A good-stop load later in this block overrides the ack clear.
            if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (f_edge) begin
                        state   <= S_START;
                        rx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!Rx_in) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {Rx_in, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    // Sampling mid stop bit re-arms IDLE half a bit early for back-to-back frames.
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                        if (Rx_in) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            overrun  <= rx_valid & ~rx_ack;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - randomized self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

    localparam int CPB    = 16;
    localparam int FRAME  = 10 * CPB;
    // Iteration after which a frame's result is visible: 2 sync stages + half bit + 9 bits.
    localparam int LOAD_I = 2 + CPB / 2 + 9 * CPB;

    logic       CLOCK = 1'b0;
    logic       reset = 1'b0;
    logic       rx_ack = 1'b0;
    logic       line = 1'b1;
    logic       sync1 = 1'b1;
    logic       Rx_in = 1'b1;
    logic       f_edge = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;

    always #5 CLOCK = ~CLOCK;

    // Upstream synchronizer model: two flops plus registered falling-edge strobe.
    always @(posedge CLOCK) begin
        sync1  <= line;
        Rx_in  <= sync1;
        f_edge <= Rx_in & ~sync1;
    end

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK     (CLOCK),
        .reset     (reset),
        .Rx_in     (Rx_in),
        .f_edge    (f_edge),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    // ack_mode: 0 none, 1 ack in the load cycle, 2 ack d cycles after the load.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_mode,
                              input int d, input int abort_at);
        logic [9:0] bits;
        logic       good;
        bits = {stop, b, 1'b0};
        good = stop;
        for (int i = 0; i < FRAME; i++) begin
            line = bits[i / CPB];
            @(posedge CLOCK);
            #1;
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1;
                exp_data  = 8'h00;
                exp_valid = 1'b0;
                check_val("async_rst_valid", 32'(rx_valid), 32'(exp_valid));
                check_val("async_rst_data", 32'(rx_data), 32'(exp_data));
                check_val("async_rst_busy", 32'(rx_busy), 32'd0);
                check_val("async_rst_ferr", 32'(frame_err), 32'd0);
                check_val("async_rst_ovr", 32'(overrun), 32'd0);
                line = 1'b1;
                idle(3);
                reset = 1'b1;
                idle(20);
                return;
            end
            if (i == 1) check_val("busy_before_start", 32'(rx_busy), 32'd0);
            if (i == 2) check_val("busy_after_start", 32'(rx_busy), 32'd1);
            if (i == LOAD_I - 1) begin
                check_val("valid_before_load", 32'(rx_valid), 32'(exp_valid));
                check_val("ferr_before_load", 32'(frame_err), 32'd0);
                if (ack_mode == 1) rx_ack = 1'b1;
            end
            if (i == LOAD_I) begin
                logic exp_ovr;
                exp_ovr = 1'b0;
                if (good) begin
                    exp_ovr   = exp_valid && (ack_mode != 1);
                    exp_valid = 1'b1;
                    exp_data  = b;
                end else if (ack_mode == 1) begin
                    exp_valid = 1'b0;
                end
                check_val("load_data", 32'(rx_data), 32'(exp_data));
                check_val("load_valid", 32'(rx_valid), 32'(exp_valid));
                check_val("load_ferr", 32'(frame_err), 32'(!good));
                check_val("load_ovr", 32'(overrun), 32'(exp_ovr));
                check_val("load_busy", 32'(rx_busy), 32'd0);
                if (ack_mode == 1) rx_ack = 1'b0;
            end
            if (i == LOAD_I + 1) begin
                check_val("ferr_one_cycle", 32'(frame_err), 32'd0);
                check_val("ovr_one_cycle", 32'(overrun), 32'd0);
            end
            if (ack_mode == 2 && i == LOAD_I + d) rx_ack = 1'b1;
            if (ack_mode == 2 && i == LOAD_I + d + 1) begin
                rx_ack    = 1'b0;
                exp_valid = 1'b0;
                check_val("ack_clears_valid", 32'(rx_valid), 32'(exp_valid));
            end
        end
        line = 1'b1;
    endtask

    initial begin
        idle(3);
        check_val("rst_data", 32'(rx_data), 32'h00);
        check_val("rst_valid", 32'(rx_valid), 32'd0);
        check_val("rst_busy", 32'(rx_busy), 32'd0);
        check_val("rst_ferr", 32'(frame_err), 32'd0);
        check_val("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b1;
        idle(5);

        send_frame(8'h55, 1'b1, 2, 0, -1);
        idle(10);

        send_frame(8'hA3, 1'b1, 2, 2, -1);
        send_frame(8'h0F, 1'b1, 2, 4, -1);
        idle(10);

        // Short low glitch is rejected at the mid start-bit sample.
        line = 1'b0;
        idle(4);
        line = 1'b1;
        idle(6);
        check_val("glitch_busy_in_start", 32'(rx_busy), 32'd1);
        idle(1);
        check_val("glitch_back_idle", 32'(rx_busy), 32'd0);
        idle(20);
        check_val("glitch_valid", 32'(rx_valid), 32'(exp_valid));
        check_val("glitch_data", 32'(rx_data), 32'(exp_data));

        send_frame(8'h3C, 1'b0, 0, 0, -1);
        idle(20);

        send_frame(8'h11, 1'b1, 0, 0, -1);
        send_frame(8'h22, 1'b1, 0, 0, -1);
        send_frame(8'h33, 1'b1, 1, 0, -1);
        idle(5);

        send_frame(8'h5A, 1'b1, 0, 0, 85);
        send_frame(8'h81, 1'b1, 2, 1, -1);
        idle(5);

        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(b, stop, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), -1);
            idle(int'($urandom_range(stop ? 0 : 3, 20)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
